// File: rtl/ew_source_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ew_source_sequencer_pkg
//  Description : Shared state encoding, default timing values and helpers
//                for the event-window source sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ew_source_sequencer_pkg;

    // Sequencer state encoding
    localparam logic [1:0] EWS_IDLE   = 2'd0;
    localparam logic [1:0] EWS_ACTIVE = 2'd1;
    localparam logic [1:0] EWS_DRAIN  = 2'd2;
    localparam logic [1:0] EWS_SETTLE = 2'd3;

    // Default tracker parameters
    localparam int EWS_DRAIN_CYCLES_DEF   = 4;
    localparam int EWS_TIMEOUT_CYCLES_DEF = 50000;
    localparam int EWS_CNT_BITS_DEF       = 8;

    // Width of a counter able to hold values 0 .. max(a,b)-1
    function automatic int ews_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ew_source_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that stops at all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count increments, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ew_source_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ew_source_sequencer
//  Description : Selects DIGI FIFO vs pattern generator as event-window
//                source, switching only between windows; tracks each window,
//                applies a post-window drain and flags windows that time out.
//  Revision    : 1.0 - initial release
// ============================================================================
module ew_source_sequencer
    import ew_source_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES   = EWS_DRAIN_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = EWS_TIMEOUT_CYCLES_DEF,
    parameter int CNT_BITS       = EWS_CNT_BITS_DEF
) (
    input  logic                serdesclk,
    input  logic                serdes_resetn,
    input  logic                pattern_req,
    input  logic                axi_start_in,
    input  logic                ew_done,
    input  logic                timeout_clr,
    output logic                pattern_en,
    output logic                axi_start_out,
    output logic                busy,
    output logic                ew_timeout,
    output logic [CNT_BITS-1:0] switch_cnt,
    output logic [CNT_BITS-1:0] start_drop_cnt
);

    // One counter serves as window age in ACTIVE and quiet time in DRAIN/SETTLE
    localparam int             CW           = ews_cnt_width(TIMEOUT_CYCLES, DRAIN_CYCLES);
    localparam logic [CW-1:0]  c_tmo_last   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  c_drain_last = CW'(DRAIN_CYCLES - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_start_pend;
    logic          r_pattern_en;
    logic          r_axi_start;
    logic          r_ew_timeout;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_pend_nxt;
    logic          w_pattern_nxt;
    logic          w_start_fire;
    logic          w_timeout_set;
    logic          w_switch_inc;
    logic          w_drop_inc;

    logic w_mismatch;
    logic w_tmo_hit;
    logic w_drain_last;

    assign w_mismatch   = (pattern_req != r_pattern_en);
    assign w_tmo_hit    = (r_cnt == c_tmo_last);
    assign w_drain_last = (r_cnt == c_drain_last);

    // State and datapath registers; reset abandons any window in flight
    always_ff @(posedge serdesclk or negedge serdes_resetn) begin
        if (!serdes_resetn) begin
            r_state      <= EWS_IDLE;
            r_cnt        <= '0;
            r_start_pend <= 1'b0;
            r_pattern_en <= 1'b0;
            r_axi_start  <= 1'b0;
            r_ew_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_start_pend <= w_pend_nxt;
            r_pattern_en <= w_pattern_nxt;
            r_axi_start  <= w_start_fire;
            if (w_timeout_set) begin
                r_ew_timeout <= 1'b1;
            end else if (timeout_clr) begin
                r_ew_timeout <= 1'b0;
            end
        end
    end

    // Next state: a source switch beats a start; done beats timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EWS_IDLE: begin
                if (w_mismatch) begin
                    w_state_nxt = EWS_SETTLE;
                end else if (axi_start_in || r_start_pend) begin
                    w_state_nxt = EWS_ACTIVE;
                end
            end
            EWS_ACTIVE: begin
                if (ew_done || w_tmo_hit) begin
                    w_state_nxt = EWS_DRAIN;
                end
            end
            EWS_DRAIN, EWS_SETTLE: begin
                if (w_drain_last) begin
                    w_state_nxt = EWS_IDLE;
                end
            end
            default: w_state_nxt = EWS_IDLE;
        endcase
    end

    // Outputs and datapath updates for the current state
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_pend_nxt    = r_start_pend;
        w_pattern_nxt = r_pattern_en;
        w_start_fire  = 1'b0;
        w_timeout_set = 1'b0;
        w_switch_inc  = 1'b0;
        w_drop_inc    = 1'b0;
        case (r_state)
            EWS_IDLE: begin
                w_cnt_nxt = '0;
                if (w_mismatch) begin
                    w_pattern_nxt = pattern_req;
                    w_switch_inc  = 1'b1;
                    // A start racing the switch waits; only one may wait
                    if (axi_start_in) begin
                        if (r_start_pend) begin
                            w_drop_inc = 1'b1;
                        end else begin
                            w_pend_nxt = 1'b1;
                        end
                    end
                end else if (axi_start_in || r_start_pend) begin
                    w_start_fire = 1'b1;
                    w_pend_nxt   = 1'b0;
                    // Pending and fresh start together open one window only
                    w_drop_inc   = axi_start_in & r_start_pend;
                end
            end
            EWS_ACTIVE: begin
                w_drop_inc = axi_start_in;
                if (ew_done) begin
                    w_cnt_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_timeout_set = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                if (axi_start_in) begin
                    if (r_start_pend) begin
                        w_drop_inc = 1'b1;
                    end else begin
                        w_pend_nxt = 1'b1;
                    end
                end
                w_cnt_nxt = w_drain_last ? '0 : (r_cnt + CW'(1));
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_switch_cnt (
        .clk   (serdesclk),
        .rst_n (serdes_resetn),
        .inc   (w_switch_inc),
        .count (switch_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_drop_cnt (
        .clk   (serdesclk),
        .rst_n (serdes_resetn),
        .inc   (w_drop_inc),
        .count (start_drop_cnt)
    );

    assign pattern_en    = r_pattern_en;
    assign axi_start_out = r_axi_start;
    assign ew_timeout    = r_ew_timeout;
    assign busy          = (r_state != EWS_IDLE) || r_start_pend;

endmodule
`default_nettype wire
